branch_predictor: RTL and testbench
===================================

# branch_predictor

- Front-end branch predictor for the MIPS pipeline.
- Fetch side: a direct-mapped table of 2-bit saturating counters plus a tagged target buffer predicts taken/not-taken and a target for `fetch_pc`.
- Resolve side: the taken flag from branch resolution (beq/bne/bgtz/bgez op encoding) trains the table. The block also raises a registered mispredict/redirect to the PC-select logic and keeps saturating branch and mispredict statistics.

## Interface

Parameters:
- `INDEX_BITS`, default 6: table index width; the table has 2^INDEX_BITS entries. Index = pc[INDEX_BITS+1:2]. Tag = pc[31:INDEX_BITS+2].

Ports:
- `clk`  in  1  Clock. Everything changes on the rising edge.
- `reset_n`  in  1  Synchronous, active-low reset.
- `fetch_pc`  in  32  PC being fetched this cycle.
- `pred_taken`  out  1  Combinational prediction for `fetch_pc`.
- `pred_target`  out  32  Combinational predicted next PC for `fetch_pc`.
- `resolve_valid`  in  1  A branch resolves this cycle.
- `resolve_op`  in  3  Branch op: 001 beq, 010 bne, 011 bgtz, 100 bgez. Any other value marks a non-branch.
- `resolve_pc`  in  32  PC of the resolving branch.
- `resolve_taken`  in  1  Actual outcome from branch resolution.
- `resolve_target`  in  32  Actual branch target.
- `resolve_pred_taken`  in  1  Prediction made at fetch, carried down the pipeline.
- `resolve_pred_target`  in  32  Predicted target carried down the pipeline.
- `stats_clr`  in  1  Clears both statistics counters.
- `mispredict`  out  1  Registered. One-cycle pulse one cycle after a mispredicted resolve.
- `redirect_pc`  out  32  Registered correct next PC; valid while `mispredict` = 1.
- `branch_count`  out  32  Count of accepted resolves; saturates at 0xFFFFFFFF.
- `mispredict_count`  out  32  Count of mispredicts; saturates at 0xFFFFFFFF.

## Operation

**Entry state**
- Each entry holds: valid (1 bit), tag (30-INDEX_BITS bits), target (32 bits), counter (2 bits).

**Lookup (combinational)**
- hit = valid[idx] and tag[idx] == fetch tag.
- pred_taken = hit and counter[idx][1].
- pred_target = target[idx] when pred_taken = 1; otherwise fetch_pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).

**Accepted resolve**
- A resolve is accepted when reset_n = 1, resolve_valid = 1 and resolve_op is in 001..100.
- Inputs are sampled at the edge of the cycle in which they are presented.

**Training on an accepted resolve**
- Tag hit, taken: counter increments, saturating at 11; target is rewritten with resolve_target.
- Tag hit, not taken: counter decrements, saturating at 00; target is unchanged.
- Tag miss, taken: the entry is allocated: valid = 1, tag and target written, counter = 10.
- Tag miss, not taken: the entry is unchanged.

**Mispredict detection**
- wrong = resolve_pred_taken != resolve_taken, or (resolve_taken = 1 and resolve_pred_target != resolve_target).
- At the next edge: mispredict <= wrong.
- When wrong = 1: redirect_pc <= resolve_target if taken, else resolve_pc + 4 (mod 2^32).
- When wrong = 0: redirect_pc holds its previous value.

**Statistics**
- Each accepted resolve increments branch_count, saturating.
- Each accepted resolve with wrong = 1 increments mispredict_count, saturating.
- stats_clr = 1 zeroes both counters. It wins over an increment in the same cycle.

**Reset (reset_n = 0 at an edge)**
- All valid bits = 0, all counters = 01.
- mispredict = 0, redirect_pc = 0, both counts = 0.
- A resolve presented during reset is dropped.
- Tags and targets need not be cleared; valid = 0 masks them.
- With reset asserted mid-operation, the first cycle after deassertion must behave exactly as after power-up reset.

## Timing

- Lookup has zero-cycle latency from fetch_pc.
- Table writes are visible to lookup starting the cycle after the resolve edge.
- Same-cycle fetch/resolve on the same index: the lookup returns the pre-update value. There is no bypass.
- mispredict and redirect_pc update exactly one cycle after the resolve cycle.
- A mispredict pulse lasts one cycle unless the next cycle's resolve is also wrong.
- Back-to-back resolves every cycle are supported with no stall.
- Two consecutive resolves to the same index see the first update, because it is written before the second is sampled.
- No ready/backpressure signal exists; every accepted resolve is consumed in its cycle.

## Test plan

1. **Cold lookup after reset.** Release reset; fetch_pc = 0x00400010 → pred_taken = 0, pred_target = 0x00400014, all counts 0.
2. **Allocate and predict.** Resolve beq at 0x00400010, taken, target 0x00400100, pred_taken = 0 → next cycle mispredict = 1, redirect_pc = 0x00400100, mispredict_count = 1. A later fetch of 0x00400010 → pred_taken = 1, pred_target = 0x00400100.
3. **Saturation and hysteresis.** On that entry, 3 more taken resolves (counter = 11), then one not-taken → still pred_taken = 1. A second not-taken → pred_taken = 0.
4. **Aliasing.** With INDEX_BITS = 6, the entry for 0x00400010 is valid. Fetch 0x00400110 (same index, different tag) → pred_taken = 0. A not-taken bne resolve at 0x00400110 leaves the entry intact.
5. **Op filtering and statistics.** resolve_op = 000 and 111 with resolve_valid = 1 → no table or count change, mispredict = 0. Preload counts near saturation via 0xFFFFFFFF forcing → the counters hold 0xFFFFFFFF. stats_clr together with a wrong resolve → counts = 0.
6. **Reset mid-stream and wrap.** Assert reset_n = 0 during a resolve burst → all prior entries predict not-taken after release. fetch_pc = 0xFFFFFFFC → pred_target = 0x00000000.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/resolve/statistics bus between the branch predictor and the pipeline.
// The pipeline side is the master; the predictor is the slave.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        resolve_valid;
  logic [2:0]  resolve_op;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_pred_taken;
  logic [31:0] resolve_pred_target;

  logic        stats_clr;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output fetch_pc, resolve_valid, resolve_op, resolve_pc, resolve_taken,
           resolve_target, resolve_pred_taken, resolve_pred_target, stats_clr,
    input  pred_taken, pred_target, mispredict, redirect_pc, branch_count,
           mispredict_count
  );

  modport slave (
    input  fetch_pc, resolve_valid, resolve_op, resolve_pc, resolve_taken,
           resolve_target, resolve_pred_taken, resolve_pred_target, stats_clr,
    output pred_taken, pred_target, mispredict, redirect_pc, branch_count,
           mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with tagged target buffer,
// registered mispredict/redirect and saturating branch statistics.
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input logic              clk,
  input logic              reset_n,
  branch_predictor_if.slave bus
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'b001,
    OP_BNE  = 3'b010,
    OP_BGTZ = 3'b011,
    OP_BGEZ = 3'b100
  } branch_op_e;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [1:0]          counter_q [ENTRIES];
  logic [1:0]          counter_d [ENTRIES];
  logic [TAG_BITS-1:0] tag_q     [ENTRIES];
  logic [TAG_BITS-1:0] tag_d     [ENTRIES];
  logic [31:0]         target_q  [ENTRIES];
  logic [31:0]         target_d  [ENTRIES];

  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  // Fetch-side lookup reads only registered table state, so a same-cycle
  // resolve to the same index is never bypassed into the prediction.
  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic                  fetch_hit;

  assign fetch_idx       = bus.fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag       = bus.fetch_pc[31:INDEX_BITS+2];
  assign fetch_hit       = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign bus.pred_taken  = fetch_hit && counter_q[fetch_idx][1];
  assign bus.pred_target = bus.pred_taken ? target_q[fetch_idx]
                                          : bus.fetch_pc + 32'd4;

  logic [INDEX_BITS-1:0] res_idx;
  logic [TAG_BITS-1:0]   res_tag;
  logic                  res_hit;
  logic                  res_accept;
  logic                  res_wrong;

  assign res_idx = bus.resolve_pc[INDEX_BITS+1:2];
  assign res_tag = bus.resolve_pc[31:INDEX_BITS+2];
  assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    valid_d            = valid_q;
    counter_d          = counter_q;
    tag_d              = tag_q;
    target_d           = target_q;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    res_accept         = 1'b0;

    case (bus.resolve_op)
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BGEZ: res_accept = bus.resolve_valid;
      default:                          res_accept = 1'b0;
    endcase

    res_wrong = (bus.resolve_pred_taken != bus.resolve_taken) ||
                (bus.resolve_taken && (bus.resolve_pred_target != bus.resolve_target));

    mispredict_d = res_accept && res_wrong;
    if (mispredict_d) begin
      redirect_pc_d = bus.resolve_taken ? bus.resolve_target
                                        : bus.resolve_pc + 32'd4;
    end

    // Clearing wins over a same-cycle increment.
    if (bus.stats_clr) begin
      branch_count_d     = '0;
      mispredict_count_d = '0;
    end else if (res_accept) begin
      if (branch_count_q != '1) branch_count_d = branch_count_q + 32'd1;
      if (res_wrong && (mispredict_count_q != '1)) begin
        mispredict_count_d = mispredict_count_q + 32'd1;
      end
    end

    if (res_accept) begin
      if (res_hit) begin
        if (bus.resolve_taken) begin
          if (counter_q[res_idx] != 2'b11) counter_d[res_idx] = counter_q[res_idx] + 2'd1;
          target_d[res_idx] = bus.resolve_target;
        end else if (counter_q[res_idx] != 2'b00) begin
          counter_d[res_idx] = counter_q[res_idx] - 2'd1;
        end
      end else if (bus.resolve_taken) begin
        valid_d[res_idx]   = 1'b1;
        tag_d[res_idx]     = res_tag;
        target_d[res_idx]  = bus.resolve_target;
        counter_d[res_idx] = 2'b10;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q            <= '0;
      for (int i = 0; i < ENTRIES; i++) counter_q[i] <= 2'b01;
      mispredict_q       <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      counter_q          <= counter_d;
      mispredict_q       <= mispredict_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // NOTE: tag/target storage has no reset; the cleared valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  assign bus.mispredict       = mispredict_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table/statistics model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_branch_predictor;
  localparam int IB = 6;
  localparam int N  = 1 << IB;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if bus ();

  branch_predictor #(.INDEX_BITS(IB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid  [N];
  int unsigned m_tag    [N];
  logic [31:0] m_target [N];
  int          m_ctr    [N];
  bit          m_misp;
  logic [31:0] m_redir;
  longint      m_bc, m_mc;
  bit          model_live = 0;

  int          mi;
  int unsigned mt;
  bit          macc, mwrong, mhit;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0;
        m_ctr[i]   = 1;
      end
      m_misp = 0; m_redir = 0; m_bc = 0; m_mc = 0;
      model_live = 1;
    end else begin
      macc   = bus.resolve_valid && bus.resolve_op >= 3'd1 && bus.resolve_op <= 3'd4;
      mwrong = (bus.resolve_pred_taken != bus.resolve_taken) ||
               (bus.resolve_taken && bus.resolve_pred_target != bus.resolve_target);
      m_misp = macc && mwrong;
      if (m_misp) m_redir = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 32'd4;
      if (bus.stats_clr) begin
        m_bc = 0; m_mc = 0;
      end else if (macc) begin
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (mwrong && m_mc < 64'hFFFF_FFFF) m_mc++;
      end
      if (macc) begin
        mi   = idx_of(bus.resolve_pc);
        mt   = tag_of(bus.resolve_pc);
        mhit = m_valid[mi] && m_tag[mi] == mt;
        if (mhit && bus.resolve_taken) begin
          m_ctr[mi]    = (m_ctr[mi] + 1 > 3) ? 3 : m_ctr[mi] + 1;
          m_target[mi] = bus.resolve_target;
        end else if (mhit) begin
          m_ctr[mi] = (m_ctr[mi] - 1 < 0) ? 0 : m_ctr[mi] - 1;
        end else if (bus.resolve_taken) begin
          m_valid[mi] = 1; m_tag[mi] = mt; m_target[mi] = bus.resolve_target; m_ctr[mi] = 2;
        end
      end
    end
  end

  // Compare process: DUT vs model on every falling edge once reset was seen.
  int          ci;
  bit          cp;
  logic [31:0] ctgt;
  always @(negedge clk) begin
    if (model_live) begin
      ci   = idx_of(bus.fetch_pc);
      cp   = m_valid[ci] && m_tag[ci] == tag_of(bus.fetch_pc) && m_ctr[ci] >= 2;
      ctgt = cp ? m_target[ci] : bus.fetch_pc + 32'd4;
      check("model_pred_taken", {31'd0, bus.pred_taken}, {31'd0, cp});
      check("model_pred_target", bus.pred_target, ctgt);
      check("model_mispredict", {31'd0, bus.mispredict}, {31'd0, m_misp});
      check("model_redirect_pc", bus.redirect_pc, m_redir);
      check("model_branch_count", bus.branch_count, m_bc[31:0]);
      check("model_mispredict_count", bus.mispredict_count, m_mc[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.resolve_valid = 1'b0;
    bus.resolve_op    = 3'b000;
    bus.stats_clr     = 1'b0;
  endtask

  task automatic resolve(input logic [2:0] op, input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    bus.resolve_valid       = 1'b1;
    bus.resolve_op          = op;
    bus.resolve_pc          = pc;
    bus.resolve_taken       = taken;
    bus.resolve_target      = tgt;
    bus.resolve_pred_taken  = ptaken;
    bus.resolve_pred_target = ptgt;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    check(name, got, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.fetch_pc = 32'h0040_0010;
    resolve(3'b001, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.resolve_valid = 1'b0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    #1;
    // 1. cold lookup
    lit("cold_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    lit("cold_pred_target", bus.pred_target, 32'h0040_0014);
    lit("cold_branch_count", bus.branch_count, 32'd0);
    lit("cold_mispredict_count", bus.mispredict_count, 32'd0);

    // 2. allocate; same-cycle lookup still sees the old entry
    tick();
    resolve(3'b001, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    #1;
    lit("no_bypass_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    tick();
    idle();
    #1;
    lit("alloc_mispredict", {31'd0, bus.mispredict}, 32'd1);
    lit("alloc_redirect", bus.redirect_pc, 32'h0040_0100);
    lit("alloc_mispredict_count", bus.mispredict_count, 32'd1);
    lit("alloc_pred_taken", {31'd0, bus.pred_taken}, 32'd1);
    lit("alloc_pred_target", bus.pred_target, 32'h0040_0100);

    // 3a. three correct taken resolves back to back -> counter saturates
    for (int i = 0; i < 3; i++) begin
      resolve(3'b001, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
      tick();
    end
    idle();
    #1;
    lit("sat_mispredict", {31'd0, bus.mispredict}, 32'd0);
    lit("sat_redirect_hold", bus.redirect_pc, 32'h0040_0100);
    lit("sat_branch_count", bus.branch_count, 32'd4);

    // 4. aliasing: same index, different tag
    bus.fetch_pc = 32'h0040_0110;
    #1;
    lit("alias_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    lit("alias_pred_target", bus.pred_target, 32'h0040_0114);
    resolve(3'b010, 32'h0040_0110, 1'b0, 32'h0040_0200, 1'b0, 32'h0040_0114);
    tick();
    idle();
    bus.fetch_pc = 32'h0040_0010;
    #1;
    lit("alias_intact_taken", {31'd0, bus.pred_taken}, 32'd1);
    lit("alias_intact_target", bus.pred_target, 32'h0040_0100);

    // 3b. hysteresis: two not-taken resolves, both mispredicted
    resolve(3'b001, 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    tick();
    #1;
    lit("hyst1_pred_taken", {31'd0, bus.pred_taken}, 32'd1);
    lit("hyst1_redirect", bus.redirect_pc, 32'h0040_0014);
    tick();
    idle();
    #1;
    lit("hyst2_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    lit("hyst2_mispredict", {31'd0, bus.mispredict}, 32'd1);
    lit("hyst2_mispredict_count", bus.mispredict_count, 32'd3);
    tick();
    lit("pulse_end", {31'd0, bus.mispredict}, 32'd0);
    lit("redirect_hold", bus.redirect_pc, 32'h0040_0014);

    // 5. op filtering
    resolve(3'b000, 32'h0040_0010, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0014);
    tick();
    resolve(3'b111, 32'h0040_0010, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0014);
    tick();
    idle();
    #1;
    lit("filter_mispredict", {31'd0, bus.mispredict}, 32'd0);
    lit("filter_branch_count", bus.branch_count, 32'd7);
    lit("filter_mispredict_count", bus.mispredict_count, 32'd3);
    lit("filter_pred_taken", {31'd0, bus.pred_taken}, 32'd0);

    // 5. saturation from a forced near-full state
    force dut.branch_count_q     = 32'hFFFF_FFFF;
    force dut.mispredict_count_q = 32'hFFFF_FFFF;
    m_bc = 64'hFFFF_FFFF;
    m_mc = 64'hFFFF_FFFF;
    #1;
    release dut.branch_count_q;
    release dut.mispredict_count_q;
    resolve(3'b011, 32'h0040_0020, 1'b1, 32'h0040_0400, 1'b0, 32'h0040_0024);
    tick();
    idle();
    #1;
    lit("sat_bc", bus.branch_count, 32'hFFFF_FFFF);
    lit("sat_mc", bus.mispredict_count, 32'hFFFF_FFFF);

    // 5. stats_clr wins over a wrong resolve
    resolve(3'b100, 32'h0040_0030, 1'b1, 32'h0040_0500, 1'b0, 32'h0040_0034);
    bus.stats_clr = 1'b1;
    tick();
    idle();
    #1;
    lit("clr_bc", bus.branch_count, 32'd0);
    lit("clr_mc", bus.mispredict_count, 32'd0);
    lit("clr_mispredict", {31'd0, bus.mispredict}, 32'd1);

    // 6. reset asserted in the middle of a resolve burst
    for (int i = 0; i < 6; i++) begin
      resolve(3'b001, 32'h0050_0000 + 32'(4 * i), 1'b1, 32'h0060_0000 + 32'(16 * i),
              1'b0, 32'h0050_0004 + 32'(4 * i));
      if (i >= 3) reset_n = 1'b0;
      tick();
    end
    reset_n = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.fetch_pc = 32'h0050_0000 + 32'(4 * i);
      #1;
      lit("rst_entry_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    end
    bus.fetch_pc = 32'h0040_0020;
    #1;
    lit("rst_old_entry", {31'd0, bus.pred_taken}, 32'd0);
    lit("rst_bc", bus.branch_count, 32'd0);
    lit("rst_redirect", bus.redirect_pc, 32'd0);
    lit("rst_mispredict", {31'd0, bus.mispredict}, 32'd0);
    bus.fetch_pc = 32'hFFFF_FFFC;
    #1;
    lit("wrap_pred_target", bus.pred_target, 32'h0000_0000);

    // wrap on the redirect path, first resolve after reset
    resolve(3'b010, 32'hFFFF_FFFC, 1'b0, 32'h0000_1000, 1'b1, 32'h0000_1000);
    tick();
    idle();
    #1;
    lit("wrap_redirect", bus.redirect_pc, 32'h0000_0000);
    lit("wrap_mispredict", {31'd0, bus.mispredict}, 32'd1);
    lit("post_rst_bc", bus.branch_count, 32'd1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
